// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Multiplies operand magnitudes over 64 or 32 cycles, then applies the result sign.
module mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op_sign,
    input  logic        op_word,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result_hi,
    output logic [63:0] result_lo
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]   state_q,  state_d;
    logic [127:0] acc_q,    acc_d;
    logic [127:0] mcand_q,  mcand_d;
    logic [63:0]  mplier_q, mplier_d;
    logic [6:0]   cnt_q,    cnt_d;
    logic         neg_q,    neg_d;
    logic         word_q,   word_d;
    logic [63:0]  hi_q,     hi_d;
    logic [63:0]  lo_q,     lo_d;

    // Operand conditioning, only consumed on the accept edge
    logic [63:0] op1, op2, mag1, mag2;
    logic        s1_neg, s2_neg;

    always_comb begin
        op1    = op_word ? {32'b0, src1[31:0]} : src1;
        op2    = op_word ? {32'b0, src2[31:0]} : src2;
        s1_neg = ~op_word & op_sign[1] & op1[63];
        s2_neg = ~op_word & (op_sign == 2'b11) & op2[63];
        // -2^63 negates to itself, which is already the correct unsigned magnitude
        mag1   = s1_neg ? (~op1 + 64'd1) : op1;
        mag2   = s2_neg ? (~op2 + 64'd1) : op2;
    end

    logic [127:0] addend, sum, fin;
    logic         last_iter;

    always_comb begin
        addend    = mplier_q[0] ? mcand_q : '0;
        sum       = acc_q + addend;
        fin       = neg_q ? (~sum + 128'd1) : sum;
        last_iter = (cnt_q == (word_q ? 7'd31 : 7'd63));
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        word_d   = word_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_d  = {64'b0, mag1};
                        mplier_d = mag2;
                        neg_d    = s1_neg ^ s2_neg;
                        word_d   = op_word;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_d    = sum;
                    mcand_d  = {mcand_q[126:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[63:1]};
                    cnt_d    = cnt_q + 7'd1;
                    if (last_iter) begin
                        if (word_q) begin
                            hi_d = '0;
                            lo_d = {{32{fin[31]}}, fin[31:0]};
                        end else begin
                            hi_d = fin[127:64];
                            lo_d = fin[63:0];
                        end
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            word_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            word_q   <= word_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result_hi = hi_q;
    assign result_lo = lo_q;

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, request present.
- in_ready, output, 1, block can accept a request.
- op_sign, input, 2, operand signedness: 2'b11 = both signed, 2'b10 = rs1 signed and rs2 unsigned, 2'b00 = both unsigned, 2'b01 = treated as 2'b00.
- op_word, input, 1, MULW: 32-bit operation.
- src1, input, 64, multiplicand.
- src2, input, 64, multiplier.
- flush, input, 1, abort any operation.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- result_hi, output, 64, product bits [127:64].
- result_lo, output, 64, product bits [63:0].
REQ-002 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-003 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-004 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-005 Accept occurs on an edge where state=IDLE, in_valid=1 and flush=0:
- register operand magnitudes and the result sign;
- clear the 128-bit accumulator and the iteration counter;
- go to BUSY.
REQ-006 Magnitude rule: each operand flagged signed and negative is two's-complement negated to its 64-bit unsigned magnitude; -2^63 yields 2^63 without overflow.
REQ-007 Result sign SHALL be the XOR of the effective operand signs; unsigned operands always count as positive.
REQ-008 Each BUSY cycle SHALL perform one radix-2 shift-add iteration: if the current multiplier bit is 1, add the shifted multiplicand to the accumulator; then advance the counter.
REQ-009 Iteration count N SHALL be 64 when op_word=0 and 32 when op_word=1; latency is fixed, with no early termination on zero operands.
REQ-010 On the edge completing iteration N-1, SHALL:
- negate the 128-bit accumulator if the result sign is 1;
- register result_hi and result_lo;
- go to DONE.
out_valid therefore rises exactly N cycles after the accept edge.
REQ-011 When op_word=1:
- operands are the low 32 bits of src1 and src2, treated as unsigned regardless of op_sign;
- result_lo = sign-extension of product[31:0];
- result_hi = 0.
REQ-012 In DONE, SHALL hold result_hi, result_lo and out_valid stable until out_ready=1; the handshake edge returns the FSM to IDLE.
REQ-013 SHALL NOT accept a new request in the DONE-to-IDLE handshake cycle; in_ready rises the following cycle.
REQ-014 flush=1 in any state SHALL return the FSM to IDLE on the next edge with no result delivered.
- flush in IDLE with in_valid=1: the request is not accepted.
- flush in DONE with out_ready=1: flush wins; the handshake counts as completed and the FSM goes to IDLE.
REQ-015 in_valid, op_sign, op_word, src1 and src2 SHALL be ignored outside the accept edge; changes during BUSY do not affect the result.
REQ-016 result_hi and result_lo SHALL keep their last values outside DONE; consumers use them only while out_valid=1.

Reset
REQ-017 While rst_n=0, independent of clk, SHALL hold:
- state = IDLE, in_ready = 1, out_valid = 0;
- accumulator, counter, result_hi and result_lo = 0.
REQ-018 Reset asserted mid-operation SHALL discard the operation; after release the block accepts a new request on the first edge.

Verification
REQ-019 Unsigned basic: src1=3, src2=5, op_sign=00, op_word=0 -> out_valid 64 cycles after accept; hi=0, lo=15.
REQ-020 Signed: src1=src2=0xFFFF_FFFF_FFFF_FFFF, op_sign=11 -> hi=0, lo=1. Same inputs with op_sign=00 -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=1.
REQ-021 MULHSU: src1=-1, src2=2, op_sign=10 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFFE. Edge case: src1=0x8000_0000_0000_0000, src2=0x8000_0000_0000_0000, op_sign=11 -> hi=0x4000_0000_0000_0000, lo=0.
REQ-022 MULW: src1=0x7FFF_FFFF, src2=2, op_word=1 -> out_valid 32 cycles after accept; lo=0xFFFF_FFFF_FFFF_FFFE, hi=0.
REQ-023 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and results stable; raise out_ready -> IDLE next edge, in_ready=1 one cycle later.
REQ-024 Abort:
- flush at BUSY iteration 20 -> IDLE next edge, out_valid never asserted; a following request 7*6 returns lo=42.
- rst_n pulse mid-BUSY -> all outputs at reset values immediately.
